// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter for one shared memory port.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   i_if_req/i_if_addr  fetch-side read request and word address
//   o_if_rdata/o_if_ack fetch read data and one-cycle completion pulse
//   i_mem_*             data-side request (we, byte enables, addr, wdata)
//   o_mem_rdata/ack     data-side read data and one-cycle completion pulse
//   o_bus_*             registered shared-port request, stable while o_bus_req=1
//   i_bus_rdata/ack     shared-port response
//   o_stall             combinational pipeline freeze request
//   o_err               one-cycle pulse when a bus access times out
//
// Parameter TIMEOUT_CYCLES (2..255): grant cycles without i_bus_ack before abort.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic [31:0] o_if_rdata,
  output logic        o_if_ack,
  input  logic        i_mem_req,
  input  logic        i_mem_we,
  input  logic [3:0]  i_mem_be,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  output logic [31:0] o_mem_rdata,
  output logic        o_mem_ack,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ack,
  output logic        o_stall,
  output logic        o_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GNT_IF  = 2'd1,
    S_GNT_MEM = 2'd2
  } state_t;

  localparam logic [7:0]  LP_CNT_LAST  = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] LP_TIMEOUT_D = 32'hDEAD_BEEF;

  // r_last_gnt: 0 = fetch granted last, 1 = data side granted last
  state_t      r_state, w_state;
  logic        r_last_gnt, w_last_gnt;
  logic [7:0]  r_cnt, w_cnt;
  logic        r_bus_req, w_bus_req;
  logic        r_bus_we, w_bus_we;
  logic [3:0]  r_bus_be, w_bus_be;
  logic [31:0] r_bus_addr, w_bus_addr;
  logic [31:0] r_bus_wdata, w_bus_wdata;
  logic        r_if_ack, w_if_ack;
  logic        r_mem_ack, w_mem_ack;
  logic [31:0] r_if_rdata, w_if_rdata;
  logic [31:0] r_mem_rdata, w_mem_rdata;
  logic        r_err, w_err;

  // A request is masked in the cycle its own ack is high, so the
  // just-completed access is not granted a second time.
  logic w_if_live, w_mem_live;
  assign w_if_live  = i_if_req  & ~r_if_ack;
  assign w_mem_live = i_mem_req & ~r_mem_ack;

  always_comb begin
    w_state     = r_state;
    w_last_gnt  = r_last_gnt;
    w_cnt       = r_cnt;
    w_bus_req   = r_bus_req;
    w_bus_we    = r_bus_we;
    w_bus_be    = r_bus_be;
    w_bus_addr  = r_bus_addr;
    w_bus_wdata = r_bus_wdata;
    w_if_rdata  = r_if_rdata;
    w_mem_rdata = r_mem_rdata;
    w_if_ack    = 1'b0;
    w_mem_ack   = 1'b0;
    w_err       = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Data side wins if it is alone, or on a tie when fetch went last.
        if (w_mem_live && (!w_if_live || !r_last_gnt)) begin
          w_state     = S_GNT_MEM;
          w_last_gnt  = 1'b1;
          w_cnt       = '0;
          w_bus_req   = 1'b1;
          w_bus_we    = i_mem_we;
          w_bus_be    = i_mem_be;
          w_bus_addr  = i_mem_addr;
          w_bus_wdata = i_mem_wdata;
        end else if (w_if_live) begin
          w_state     = S_GNT_IF;
          w_last_gnt  = 1'b0;
          w_cnt       = '0;
          w_bus_req   = 1'b1;
          w_bus_we    = 1'b0;
          w_bus_be    = 4'hF;
          w_bus_addr  = i_if_addr;
          w_bus_wdata = '0;
        end
      end
      S_GNT_IF: begin
        if (i_bus_ack) begin
          w_state    = S_IDLE;
          w_bus_req  = 1'b0;
          w_if_ack   = 1'b1;
          w_if_rdata = i_bus_rdata;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state    = S_IDLE;
          w_bus_req  = 1'b0;
          w_if_ack   = 1'b1;
          w_if_rdata = LP_TIMEOUT_D;
          w_err      = 1'b1;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      S_GNT_MEM: begin
        if (i_bus_ack) begin
          w_state     = S_IDLE;
          w_bus_req   = 1'b0;
          w_mem_ack   = 1'b1;
          w_mem_rdata = i_bus_rdata;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state     = S_IDLE;
          w_bus_req   = 1'b0;
          w_mem_ack   = 1'b1;
          w_mem_rdata = LP_TIMEOUT_D;
          w_err       = 1'b1;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state   = S_IDLE;
        w_bus_req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_last_gnt  <= 1'b0;
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_be    <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_last_gnt  <= w_last_gnt;
      r_cnt       <= w_cnt;
      r_bus_req   <= w_bus_req;
      r_bus_we    <= w_bus_we;
      r_bus_be    <= w_bus_be;
      r_bus_addr  <= w_bus_addr;
      r_bus_wdata <= w_bus_wdata;
      r_if_ack    <= w_if_ack;
      r_mem_ack   <= w_mem_ack;
      r_if_rdata  <= w_if_rdata;
      r_mem_rdata <= w_mem_rdata;
      r_err       <= w_err;
    end
  end

  assign o_bus_req   = r_bus_req;
  assign o_bus_we    = r_bus_we;
  assign o_bus_be    = r_bus_be;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;
  assign o_if_ack    = r_if_ack;
  assign o_mem_ack   = r_mem_ack;
  assign o_if_rdata  = r_if_rdata;
  assign o_mem_rdata = r_mem_rdata;
  assign o_err       = r_err;
  assign o_stall     = (i_if_req & ~r_if_ack) | (i_mem_req & ~r_mem_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (TIMEOUT_CYCLES = 16).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        stall;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_if_req    (if_req),
    .i_if_addr   (if_addr),
    .o_if_rdata  (if_rdata),
    .o_if_ack    (if_ack),
    .i_mem_req   (mem_req),
    .i_mem_we    (mem_we),
    .i_mem_be    (mem_be),
    .i_mem_addr  (mem_addr),
    .i_mem_wdata (mem_wdata),
    .o_mem_rdata (mem_rdata),
    .o_mem_ack   (mem_ack),
    .o_bus_req   (bus_req),
    .o_bus_we    (bus_we),
    .o_bus_be    (bus_be),
    .o_bus_addr  (bus_addr),
    .o_bus_wdata (bus_wdata),
    .i_bus_rdata (bus_rdata),
    .i_bus_ack   (bus_ack),
    .o_stall     (stall),
    .o_err       (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_be = '0; mem_addr = '0; mem_wdata = '0;
    bus_rdata = '0; bus_ack = 1'b0;

    // ---- reset state ----
    tick(); tick();
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_bus_be", 32'(bus_be), 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_acks_err", {29'd0, if_ack, mem_ack, err}, 0);
    chk("rst_stall", 32'(stall), 0);
    rst = 1'b0;

    // ---- bus ack in IDLE is ignored ----
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    tick();
    chk("idle_ack_bus_req", 32'(bus_req), 0);
    chk("idle_ack_acks", {30'd0, if_ack, mem_ack}, 0);
    bus_ack = 1'b0;

    // ---- zero-wait fetch ----
    if_req = 1'b1; if_addr = 32'h100;
    #1 chk("zw_stall_pending", 32'(stall), 1);
    tick();                                     // N+1
    chk("zw_bus_req", 32'(bus_req), 1);
    chk("zw_bus_addr", bus_addr, 32'h100);
    chk("zw_bus_we_be", {27'd0, bus_we, bus_be}, 32'h0F);
    chk("zw_bus_wdata", bus_wdata, 0);
    bus_ack = 1'b1; bus_rdata = 32'h0000_0013;
    tick();                                     // N+2
    chk("zw_if_ack", 32'(if_ack), 1);
    chk("zw_if_rdata", if_rdata, 32'h13);
    chk("zw_bus_req_drop", 32'(bus_req), 0);
    chk("zw_stall_ack", 32'(stall), 0);
    chk("zw_err", 32'(err), 0);
    bus_ack = 1'b0; bus_rdata = 32'hFFFF_FFFF;
    tick();                                     // held req ignored in ack cycle
    if_req = 1'b0;
    chk("zw_no_regrant", 32'(bus_req), 0);
    chk("zw_ack_pulse", 32'(if_ack), 0);
    chk("zw_rdata_hold", if_rdata, 32'h13);

    // ---- store, fields stable while requester changes ----
    mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'b0011;
    mem_addr = 32'h2000_0004; mem_wdata = 32'h0000_A5A5;
    tick();
    chk("st_bus_req", 32'(bus_req), 1);
    chk("st_bus_we_be", {27'd0, bus_we, bus_be}, 32'h13);
    chk("st_bus_addr", bus_addr, 32'h2000_0004);
    chk("st_bus_wdata", bus_wdata, 32'h0000_A5A5);
    mem_wdata = 32'h0000_FFFF; mem_addr = 32'h0; mem_we = 1'b0; mem_be = 4'hF;
    tick();
    chk("st_hold_wdata", bus_wdata, 32'h0000_A5A5);
    chk("st_hold_addr", bus_addr, 32'h2000_0004);
    mem_req = 1'b0;                             // dropped before ack
    tick();
    chk("st_hold_we_be", {27'd0, bus_we, bus_be}, 32'h13);
    chk("st_hold_req", 32'(bus_req), 1);
    bus_ack = 1'b1; bus_rdata = 32'h77;
    tick();
    chk("st_mem_ack", 32'(mem_ack), 1);
    chk("st_mem_rdata", mem_rdata, 32'h77);
    chk("st_if_ack", 32'(if_ack), 0);
    bus_ack = 1'b0;
    tick();
    chk("st_ack_pulse", 32'(mem_ack), 0);

    // ---- contention after reset: MEM, IF, MEM, IF ----
    rst = 1'b1; tick(); rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h40;
    mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF; mem_addr = 32'h80; mem_wdata = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      logic is_mem;
      is_mem = (k % 2 == 0);
      tick();
      chk($sformatf("ct%0d_bus_req", k), 32'(bus_req), 1);
      chk($sformatf("ct%0d_bus_addr", k), bus_addr, is_mem ? 32'h80 : 32'h40);
      chk($sformatf("ct%0d_stall", k), 32'(stall), 1);
      for (int unsigned w = 0; w < 3; w++) tick();
      chk($sformatf("ct%0d_wait_req", k), 32'(bus_req), 1);
      bus_ack = 1'b1; bus_rdata = 32'(k + 1);
      tick();
      chk($sformatf("ct%0d_acks", k), {30'd0, if_ack, mem_ack}, is_mem ? 32'd1 : 32'd2);
      chk($sformatf("ct%0d_rdata", k), is_mem ? mem_rdata : if_rdata, 32'(k + 1));
      bus_ack = 1'b0;
    end
    if_req = 1'b0; mem_req = 1'b0;
    tick();
    chk("ct_idle", 32'(bus_req), 0);

    // ---- timeout: no ack for 16 grant cycles ----
    mem_req = 1'b1; mem_addr = 32'h300;
    tick();                                     // grant cycle 1
    mem_req = 1'b0;
    for (int unsigned i = 0; i < 15; i++) tick();   // grant cycle 16
    chk("to_req_c16", 32'(bus_req), 1);
    chk("to_err_early", 32'(err), 0);
    tick();
    chk("to_err", 32'(err), 1);
    chk("to_mem_ack", 32'(mem_ack), 1);
    chk("to_mem_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("to_bus_req", 32'(bus_req), 0);
    tick();
    chk("to_err_pulse", 32'(err), 0);

    // ---- ack on the 16th cycle wins over timeout ----
    mem_req = 1'b1; mem_addr = 32'h304;
    tick();
    mem_req = 1'b0;
    for (int unsigned i = 0; i < 15; i++) tick();
    bus_ack = 1'b1; bus_rdata = 32'h55;
    tick();
    chk("to16_err", 32'(err), 0);
    chk("to16_mem_ack", 32'(mem_ack), 1);
    chk("to16_mem_rdata", mem_rdata, 32'h55);
    bus_ack = 1'b0;
    tick();

    // ---- reset mid-wait, pending MEM granted first ----
    if_req = 1'b1; if_addr = 32'h500;
    tick();
    chk("rm_gnt_if", bus_addr, 32'h500);
    mem_req = 1'b1; mem_addr = 32'h600;
    tick();
    rst = 1'b1;
    #1;
    chk("rm_bus_req", 32'(bus_req), 0);
    chk("rm_bus_addr", bus_addr, 0);
    chk("rm_bus_be", 32'(bus_be), 0);
    chk("rm_if_rdata", if_rdata, 0);
    chk("rm_mem_rdata", mem_rdata, 0);
    tick();
    chk("rm_no_ack_err", {29'd0, if_ack, mem_ack, err}, 0);
    rst = 1'b0;
    tick();
    chk("rm_first_mem", bus_addr, 32'h600);
    chk("rm_first_req", 32'(bus_req), 1);
    bus_ack = 1'b1; bus_rdata = 32'h9;
    tick();
    chk("rm_mem_ack", 32'(mem_ack), 1);
    bus_ack = 1'b0; mem_req = 1'b0;
    tick();
    chk("rm_then_if", bus_addr, 32'h500);
    if_req = 1'b0;
    bus_ack = 1'b1;
    tick();
    chk("rm_if_ack", 32'(if_ack), 1);
    bus_ack = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, bus-ack wait cycles before a transaction is aborted (legal range 2..255).
REQ-002 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports i_if_req input 1, i_if_addr input 32: fetch-side request and word address.
REQ-005 SHALL have ports o_if_rdata output 32, o_if_ack output 1: fetch read data and one-cycle completion pulse.
REQ-006 SHALL have ports i_mem_req input 1, i_mem_we input 1, i_mem_be input 4, i_mem_addr input 32, i_mem_wdata input 32: data-side request.
REQ-007 SHALL have ports o_mem_rdata output 32, o_mem_ack output 1: data-side read data and one-cycle completion pulse.
REQ-008 SHALL have ports o_bus_req output 1, o_bus_we output 1, o_bus_be output 4, o_bus_addr output 32, o_bus_wdata output 32: shared memory port request.
REQ-009 SHALL have ports i_bus_rdata input 32, i_bus_ack input 1: shared memory port response.
REQ-010 SHALL have ports o_stall output 1 (pipeline freeze request) and o_err output 1 (one-cycle timeout pulse).

Function
REQ-011 SHALL implement FSM states IDLE, GNT_IF, GNT_MEM; all outputs registered.
REQ-012 IDLE: sample requests; only-IF -> GNT_IF; only-MEM -> GNT_MEM; both -> grant the requester not granted last (round-robin bit last_gnt); none -> stay IDLE.
REQ-013 SHALL update last_gnt on every grant.
REQ-014 On grant, SHALL latch the winner's addr/we/be/wdata into o_bus_* and assert o_bus_req the next cycle; fetch grants drive o_bus_we=0, o_bus_be=4'hF, o_bus_wdata=0.
REQ-015 o_bus_* SHALL stay stable while o_bus_req=1, independent of requester inputs changing.
REQ-016 On i_bus_ack=1 in GNT_x: next cycle o_bus_req=0, o_x_ack=1 for exactly one cycle, o_x_rdata=i_bus_rdata captured (writes: captured value, don't-care to requester), state -> IDLE.
REQ-017 o_x_rdata SHALL hold its last value until the next completion on that side.
REQ-018 A requester's req SHALL be ignored during the cycle its ack is high (prevents re-grant of the completed request).
REQ-019 i_bus_ack while in IDLE SHALL be ignored.
REQ-020 Zero-wait latency: req sampled at cycle N -> o_bus_req at N+1 -> ack at N+2 when i_bus_ack=1 at N+1.
REQ-021 Wait counter SHALL reset on grant, increment each GNT_x cycle without i_bus_ack; at count==TIMEOUT_CYCLES-1 with no ack: o_bus_req=0, o_x_ack=1, o_x_rdata=32'hDEAD_BEEF, o_err=1 one cycle, state -> IDLE.
REQ-022 i_bus_ack in the same cycle as timeout expiry SHALL win: normal completion, no o_err.
REQ-023 Requester dropping req before its ack SHALL NOT abort the transaction; ack still pulses.
REQ-024 o_stall SHALL be combinational: (i_if_req & ~o_if_ack) | (i_mem_req & ~o_mem_ack).
REQ-025 Requests arriving in the ack cycle of the other requester SHALL be granted from the following IDLE cycle; no request SHALL be lost while held.

Reset
REQ-026 On i_rst=1, asynchronously: state=IDLE, o_bus_req=0, o_bus_we=0, o_bus_be=0, o_bus_addr=0, o_bus_wdata=0, o_if_ack=0, o_mem_ack=0, o_if_rdata=0, o_mem_rdata=0, o_err=0, counter=0, last_gnt=IF (MEM wins first tie).
REQ-027 Reset asserted mid-transaction SHALL abandon it with no ack and no o_err; first post-reset grant follows REQ-012.

Verification
REQ-028 Zero-wait fetch: i_if_req=1, addr=0x100, i_bus_ack returned in first o_bus_req cycle with rdata=0x00000013 -> o_bus_addr=0x100 at N+1, o_if_ack=1 and o_if_rdata=0x13 at N+2.
REQ-029 Contention: both req held after reset, each bus access 3 wait cycles -> grant order MEM, IF, MEM, IF; o_stall=1 until each side acked.
REQ-030 Store: i_mem_we=1, be=4'b0011, addr=0x2000_0004, wdata=0xA5A5 -> bus fields match exactly and stay stable while requester changes wdata mid-wait.
REQ-031 Timeout: TIMEOUT_CYCLES=16, no i_bus_ack -> after 16 GNT cycles o_err=1, o_mem_ack=1, o_mem_rdata=0xDEADBEEF; ack on the 16th cycle instead -> normal completion, o_err=0.
REQ-032 Reset mid-wait: i_rst pulsed during GNT_IF -> all outputs 0 immediately, no ack; pending MEM request then granted first.
